// File: rtl/event_counter_p.sv
// ---------------------------------------------------------------------------
// event_counter_p
//
// Counts rising edges of an asynchronous level input after synchronising it
// into the clk domain. The count runs 0..MAX_COUNT, up or down, and either
// wraps or saturates at the boundaries. A parallel load overrides counting.
//
// Ports
//   clk       system clock, rising-edge active
//   rst       synchronous reset, active-high
//   i         asynchronous event input; each rising edge is one event
//   en        count enable; events seen while low are discarded
//   up_dn     1 = count up, 0 = count down (value in the event cycle counts)
//   load      parallel load strobe (beats any event in the same cycle)
//   load_val  value to load, clamped to MAX_COUNT
//   clr_ovf   clears the sticky overflow flag
//   count     current count, registered
//   evt       one-cycle pulse per rising edge of synchronised i (ignores en)
//   tc        registered one-cycle pulse after a boundary event
//   ovf       sticky overflow/underflow flag
// ---------------------------------------------------------------------------
module event_counter_p #(
   parameter int WIDTH       = 4,
   parameter int MAX_COUNT   = 2**WIDTH - 1,
   parameter int SYNC_STAGES = 2,
   parameter bit SATURATE    = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] count,
   output logic             evt,
   output logic             tc,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   i_s;
   logic                   prev;

   logic [WIDTH-1:0]       count_nxt;
   logic                   tc_nxt;
   logic                   ovf_set;

   // Synchroniser chain and edge-history flop. The edge detector tracks i
   // regardless of en, so enabling mid-level never fabricates an event.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours, as real flops do.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         prev   <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], i};
         prev   <= i_s;
      end
   end

   assign i_s = sync_q[SYNC_STAGES-1];
   assign evt = i_s & ~prev;

   // Next-count logic. Boundaries are compared against MAX_COUNT, not the
   // natural 2**WIDTH roll-over, so a non-power-of-two modulus works.
   // NOTE: every output of this block gets a default first, so no path
   // leaves a value unassigned and no latch can be inferred.
   always_comb begin
      count_nxt = count;
      tc_nxt    = 1'b0;
      ovf_set   = 1'b0;
      if (load) begin
         count_nxt = (load_val > MAX_V) ? MAX_V : load_val;
      end else if (en && evt) begin
         if (up_dn) begin
            if (count == MAX_V) begin
               tc_nxt    = 1'b1;
               ovf_set   = 1'b1;
               count_nxt = SATURATE ? count : '0;
            end else begin
               count_nxt = count + 1'b1;
            end
         end else begin
            if (count == '0) begin
               tc_nxt    = 1'b1;
               ovf_set   = 1'b1;
               count_nxt = SATURATE ? count : MAX_V;
            end else begin
               count_nxt = count - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         tc    <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         count <= count_nxt;
         tc    <= tc_nxt;
         // A boundary event on the same edge as clr_ovf leaves the flag set.
         if (ovf_set)
            ovf <= 1'b1;
         else if (clr_ovf)
            ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_event_counter_p.sv
// ---------------------------------------------------------------------------
// tb_event_counter_p
//
// Three counters share one set of inputs:
//   inst0  WIDTH=4, MAX_COUNT=15, wrap
//   inst1  WIDTH=4, MAX_COUNT=9,  wrap
//   inst2  WIDTH=4, MAX_COUNT=9,  saturate
// A reference model predicts each counter from the history of sampled i
// values and the counting rules; scenario tasks also check fixed values.
// ---------------------------------------------------------------------------
module tb_event_counter_p;

   logic       clk = 1'b0;
   logic       rst, i, en, up_dn, load, clr_ovf;
   logic [3:0] load_val;

   logic [2:0][3:0] cnt_o;
   logic [2:0]      evt_o, tc_o, ovf_o;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   event_counter_p #(.WIDTH(4)) u0 (
      .clk(clk), .rst(rst), .i(i), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val), .clr_ovf(clr_ovf),
      .count(cnt_o[0]), .evt(evt_o[0]), .tc(tc_o[0]), .ovf(ovf_o[0]));

   event_counter_p #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b0)) u1 (
      .clk(clk), .rst(rst), .i(i), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val), .clr_ovf(clr_ovf),
      .count(cnt_o[1]), .evt(evt_o[1]), .tc(tc_o[1]), .ovf(ovf_o[1]));

   event_counter_p #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b1)) u2 (
      .clk(clk), .rst(rst), .i(i), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val), .clr_ovf(clr_ovf),
      .count(cnt_o[2]), .evt(evt_o[2]), .tc(tc_o[2]), .ovf(ovf_o[2]));

   // ---------------- reference model ----------------
   int mx[3]   = '{15, 9, 9};
   bit msat[3] = '{1'b0, 1'b0, 1'b1};
   int m_cnt[3];
   bit m_tc[3];
   bit m_ovf[3];
   // hist[j] = value of i sampled (j+1) edges ago; reset forgets it all
   bit hist[3] = '{1'b0, 1'b0, 1'b0};
   bit exp_evt;

   int evt_seen[3];
   int tc_seen[3];

   // An event is applied at an edge when i was seen high two edges
   // earlier and low three edges earlier.
   task automatic model_update();
      bit ev;
      ev = hist[1] && !hist[2];
      for (int k = 0; k < 3; k++) begin
         if (rst) begin
            m_cnt[k] = 0; m_tc[k] = 1'b0; m_ovf[k] = 1'b0;
         end else begin
            bit set_o;
            set_o    = 1'b0;
            m_tc[k]  = 1'b0;
            if (load) begin
               m_cnt[k] = (int'(load_val) > mx[k]) ? mx[k] : int'(load_val);
            end else if (en && ev) begin
               if (up_dn) begin
                  if (m_cnt[k] == mx[k]) begin
                     set_o = 1'b1;
                     if (!msat[k]) m_cnt[k] = 0;
                  end else m_cnt[k] = m_cnt[k] + 1;
               end else begin
                  if (m_cnt[k] == 0) begin
                     set_o = 1'b1;
                     if (!msat[k]) m_cnt[k] = mx[k];
                  end else m_cnt[k] = m_cnt[k] - 1;
               end
            end
            m_tc[k] = set_o;
            if (set_o) m_ovf[k] = 1'b1;
            else if (clr_ovf) m_ovf[k] = 1'b0;
         end
      end
      if (rst) hist = '{1'b0, 1'b0, 1'b0};
      else begin
         hist[2] = hist[1];
         hist[1] = hist[0];
         hist[0] = i;
      end
      exp_evt = hist[1] && !hist[2];
   endtask

   // One clock: inputs already set, model follows the edge, outputs are
   // observed on the falling edge.
   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         evt_seen[k] += int'(evt_o[k]);
         tc_seen[k]  += int'(tc_o[k]);
      end
   endtask

   task automatic clear_tallies();
      for (int k = 0; k < 3; k++) begin
         evt_seen[k] = 0;
         tc_seen[k]  = 0;
      end
   endtask

   task automatic pulse(input int h, input int l);
      i = 1'b1;
      repeat (h) step();
      i = 1'b0;
      repeat (l) step();
   endtask

   task automatic do_load(input logic [3:0] v);
      load_val = v; load = 1'b1;
      step();
      load = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1; i = 1'b0; en = 1'b1; up_dn = 1'b1; load = 1'b0;
      load_val = '0; clr_ovf = 1'b0;
      repeat (2) step();
      for (int k = 0; k < 3; k++) begin
         n_tests++;
         if (cnt_o[k] !== 4'd0 || tc_o[k] !== 1'b0 || ovf_o[k] !== 1'b0 || evt_o[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset inst%0d: count=%0d tc=%b ovf=%b evt=%b, expected 0 0 0 0",
                     k, cnt_o[k], tc_o[k], ovf_o[k], evt_o[k]);
         end
      end
      rst = 1'b0;
      step();
      clear_tallies();
      i = 1'b1;
      step(); step();
      n_tests++;
      if (evt_o[0] !== 1'b1 || cnt_o[0] !== 4'd0) begin
         n_fail++;
         $display("FAIL latency_edge2: evt=%b count=%0d, expected evt=1 count=0", evt_o[0], cnt_o[0]);
      end
      step();
      n_tests++;
      if (cnt_o[0] !== 4'd1) begin
         n_fail++;
         $display("FAIL latency_edge3: count=%0d, expected 1", cnt_o[0]);
      end
      step();
      i = 1'b0;
      repeat (4) step();
      repeat (4) pulse(4, 4);
      for (int k = 0; k < 3; k++) begin
         n_tests++;
         if (cnt_o[k] !== 4'd5 || evt_seen[k] != 5 || tc_seen[k] != 0 || ovf_o[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_count inst%0d: count=%0d evts=%0d tcs=%0d ovf=%b, expected 5 5 0 0",
                     k, cnt_o[k], evt_seen[k], tc_seen[k], ovf_o[k]);
         end
      end
   endtask

   task automatic test_wrap_up();
      up_dn = 1'b1;
      do_load(4'd8);
      clear_tallies();
      pulse(4, 4);
      n_tests++;
      if (cnt_o[1] !== 4'd9 || tc_seen[1] != 0) begin
         n_fail++;
         $display("FAIL wrap_first: count=%0d tcs=%0d, expected 9 0", cnt_o[1], tc_seen[1]);
      end
      pulse(4, 4);
      n_tests++;
      if (cnt_o[1] !== 4'd0 || tc_seen[1] != 1 || ovf_o[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL wrap_second: count=%0d tcs=%0d ovf=%b, expected 0 1 1", cnt_o[1], tc_seen[1], ovf_o[1]);
      end
      n_tests++;
      if (cnt_o[2] !== 4'd9 || tc_seen[2] != 1 || ovf_o[2] !== 1'b1 || cnt_o[0] !== 4'd10 || ovf_o[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap_others: sat count=%0d tcs=%0d ovf=%b, w15 count=%0d ovf=%b, expected 9 1 1, 10 0",
                  cnt_o[2], tc_seen[2], ovf_o[2], cnt_o[0], ovf_o[0]);
      end
      repeat (3) step();
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      n_tests++;
      if (ovf_o[1] !== 1'b0 || ovf_o[2] !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap_clr_ovf: ovf1=%b ovf2=%b, expected 0 0", ovf_o[1], ovf_o[2]);
      end
   endtask

   task automatic test_sat_down();
      do_load(4'd1);
      up_dn = 1'b0;
      clear_tallies();
      for (int n = 0; n < 3; n++) begin
         pulse(4, 4);
         n_tests++;
         if (cnt_o[2] !== 4'd0) begin
            n_fail++;
            $display("FAIL sat_down_ev%0d: count=%0d, expected 0", n + 1, cnt_o[2]);
         end
      end
      n_tests++;
      if (tc_seen[2] != 2 || ovf_o[2] !== 1'b1) begin
         n_fail++;
         $display("FAIL sat_down_flags: tcs=%0d ovf=%b, expected 2 1", tc_seen[2], ovf_o[2]);
      end
      n_tests++;
      if (cnt_o[1] !== 4'd8 || tc_seen[1] != 1) begin
         n_fail++;
         $display("FAIL wrap_down: count=%0d tcs=%0d, expected 8 1", cnt_o[1], tc_seen[1]);
      end
   endtask

   task automatic test_load_priority();
      up_dn = 1'b1;
      clear_tallies();
      i = 1'b1;
      step(); step();
      load_val = 4'd15; load = 1'b1;
      step();
      load = 1'b0;
      n_tests++;
      if (cnt_o[0] !== 4'd15 || cnt_o[1] !== 4'd9 || cnt_o[2] !== 4'd9 || tc_o !== 3'b000) begin
         n_fail++;
         $display("FAIL load_clamp: counts=%0d,%0d,%0d tc=%b, expected 15,9,9 tc=000",
                  cnt_o[0], cnt_o[1], cnt_o[2], tc_o);
      end
      step();
      i = 1'b0;
      repeat (4) step();
      n_tests++;
      if (cnt_o[1] !== 4'd9 || evt_seen[1] != 1 || tc_seen[1] != 0) begin
         n_fail++;
         $display("FAIL load_drops_event: count=%0d evts=%0d tcs=%0d, expected 9 1 0",
                  cnt_o[1], evt_seen[1], tc_seen[1]);
      end
   endtask

   task automatic test_enable();
      up_dn = 1'b1;
      do_load(4'd3);
      en = 1'b0;
      clear_tallies();
      repeat (3) pulse(4, 4);
      for (int k = 0; k < 3; k++) begin
         n_tests++;
         if (cnt_o[k] !== 4'd3 || evt_seen[k] != 3 || tc_seen[k] != 0) begin
            n_fail++;
            $display("FAIL en_gate inst%0d: count=%0d evts=%0d tcs=%0d, expected 3 3 0",
                     k, cnt_o[k], evt_seen[k], tc_seen[k]);
         end
      end
      i = 1'b1;
      repeat (4) step();
      en = 1'b1;
      repeat (3) step();
      i = 1'b0;
      repeat (4) step();
      n_tests++;
      if (cnt_o[0] !== 4'd3) begin
         n_fail++;
         $display("FAIL en_mid_level: count=%0d, expected 3", cnt_o[0]);
      end
      pulse(4, 4);
      n_tests++;
      if (cnt_o[0] !== 4'd4 || cnt_o[1] !== 4'd4 || cnt_o[2] !== 4'd4) begin
         n_fail++;
         $display("FAIL en_next_edge: counts=%0d,%0d,%0d, expected 4,4,4", cnt_o[0], cnt_o[1], cnt_o[2]);
      end
   endtask

   task automatic test_ovf_set_clear();
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      up_dn = 1'b1;
      do_load(4'd9);
      i = 1'b1;
      step(); step();
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      n_tests++;
      if (ovf_o[1] !== 1'b1 || ovf_o[2] !== 1'b1 || cnt_o[1] !== 4'd0 || cnt_o[2] !== 4'd9 || ovf_o[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL set_beats_clear: ovf=%b counts=%0d,%0d, expected ovf=110 counts 0,9",
                  ovf_o, cnt_o[1], cnt_o[2]);
      end
      step();
      i = 1'b0;
      repeat (4) step();
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      n_tests++;
      if (ovf_o !== 3'b000) begin
         n_fail++;
         $display("FAIL clr_alone: ovf=%b, expected 000", ovf_o);
      end
      do_load(4'd9);
      pulse(4, 4);
      i = 1'b1;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_tests++;
      if (cnt_o !== '0 || ovf_o !== 3'b000 || tc_o !== 3'b000) begin
         n_fail++;
         $display("FAIL mid_reset: counts=%0d,%0d,%0d ovf=%b tc=%b, expected 0s",
                  cnt_o[0], cnt_o[1], cnt_o[2], ovf_o, tc_o);
      end
      repeat (4) step();
      i = 1'b0;
      repeat (4) step();
      n_tests++;
      if (cnt_o[0] !== 4'd1 || cnt_o[1] !== 4'd1) begin
         n_fail++;
         $display("FAIL high_at_release: counts=%0d,%0d, expected 1,1", cnt_o[0], cnt_o[1]);
      end
   endtask

   task automatic test_random();
      int hold;
      hold = 3;
      for (int c = 0; c < 600; c++) begin
         if (hold == 0) begin
            i = ~i;
            hold = $urandom_range(5, 2);
         end
         hold--;
         en       = ($urandom_range(3, 0) != 0);
         up_dn    = $urandom_range(1, 0) != 0;
         load     = ($urandom_range(11, 0) == 0);
         load_val = 4'($urandom_range(15, 0));
         clr_ovf  = ($urandom_range(9, 0) == 0);
         rst      = ($urandom_range(79, 0) == 0);
         step();
         for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (cnt_o[k] !== 4'(m_cnt[k]) || tc_o[k] !== m_tc[k] || ovf_o[k] !== m_ovf[k] || evt_o[k] !== exp_evt) begin
               n_fail++;
               $display("FAIL random c%0d inst%0d: count=%0d tc=%b ovf=%b evt=%b, expected %0d %b %b %b",
                        c, k, cnt_o[k], tc_o[k], ovf_o[k], evt_o[k], m_cnt[k], m_tc[k], m_ovf[k], exp_evt);
            end
         end
      end
      rst = 1'b0; load = 1'b0; clr_ovf = 1'b0;
   endtask

   initial begin
      test_reset();
      test_wrap_up();
      test_sat_down();
      test_load_priority();
      test_enable();
      test_ovf_set_clear();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/event_counter_p.md
Name: event_counter_p

Overview:
- Parametrised event counter that counts rising edges of an asynchronous level input.
- Next-generation counter block: configurable width and modulus, up/down direction, wrap or saturate mode, parallel load, terminal-count pulse and sticky overflow flag.
- Sits between raw event sources (buttons, sensor strobes, slow handshake lines) and control logic that needs a clean, clocked count.

Parameters:
- WIDTH, 4, counter width in bits (>=2).
- MAX_COUNT, 2**WIDTH-1, highest count value; the counter runs 0..MAX_COUNT. Must be <= 2**WIDTH-1.
- SYNC_STAGES, 2, number of synchroniser flops on i (>=2).
- SATURATE, 0, 0 = wrap at boundaries, 1 = hold at boundaries.

Ports:
- clk  in  1  system clock; all logic updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- i  in  1  asynchronous event input; each rising edge is one event.
- en  in  1  count enable; when low, events are discarded (not queued).
- up_dn  in  1  1 = count up, 0 = count down; sampled in the cycle the event is applied.
- load  in  1  parallel load strobe.
- load_val  in  WIDTH  value to load.
- clr_ovf  in  1  clears the ovf flag.
- count  out  WIDTH  current count, registered.
- evt  out  1  one-cycle pulse on each detected rising edge of synchronised i, regardless of en.
- tc  out  1  registered one-cycle pulse when a boundary event occurs.
- ovf  out  1  sticky flag; set on overflow or underflow, held until cleared.

Behaviour:
- Reset: on rst=1 at a clk edge, count=0, tc=0, ovf=0, all synchroniser flops=0, and the edge-history flop=0.
- If i is high at reset release, one event is detected after sync latency. This is intended.
- Synchroniser: i passes through SYNC_STAGES flops, giving i_s.
- Edge detect: prev <= i_s every cycle. evt = i_s & ~prev (combinational from flops).
- Latency: with i high and setup-met before edge E0, evt is high after edge E(SYNC_STAGES-1). count updates at edge E(SYNC_STAGES). With SYNC_STAGES=2, count changes at the 3rd clk edge.
- Pulse width: i pulses shorter than one clk period may be missed. i must stay stable for at least 2 clk periods, high and low, to be counted.
- Priority per edge: rst > load > (en & evt) > hold.
- Load: count <= min(load_val, MAX_COUNT). Any event in the same cycle is dropped. tc=0 and ovf is unchanged.
- Count up (up_dn=1):
  - count<MAX_COUNT: count+1.
  - count==MAX_COUNT: count <= 0 if SATURATE=0, else hold. tc pulses and ovf is set.
- Count down (up_dn=0):
  - count>0: count-1.
  - count==0: count <= MAX_COUNT if SATURATE=0, else hold. tc pulses and ovf is set.
- tc: high for exactly the cycle after the boundary event edge; low otherwise.
- Saturated boundaries: every further boundary event in saturate mode pulses tc again.
- ovf:
  - Set beats clear: if a set condition and clr_ovf=1 occur on the same edge, ovf=1.
  - Otherwise clr_ovf=1 gives ovf <= 0.
- en=0: count holds and tc=0. evt still pulses, and the edge detector keeps tracking i, so raising en mid-level does not create a false event.
- Direction change: up_dn may change on any cycle. Only its value in the event cycle matters.
- rst mid-count: count returns to 0 on the next edge, and any in-flight synchronised edge is lost.
- Arithmetic: all count math is unsigned WIDTH bits. Comparisons are against MAX_COUNT, never the natural 2**WIDTH wrap.

Test Plan:
- Reset/basic (WIDTH=4, defaults): assert rst 2 cycles, then drive 5 clean pulses of i (4 clk high/4 low) with en=1, up_dn=1 -> count=5, evt pulses 5 times, tc=0, ovf=0. First count change occurs at the 3rd edge after i rises.
- Wrap up (MAX_COUNT=9, SATURATE=0): load 8, then 2 events -> count 9 then 0. tc pulses once on the 9->0 event, and ovf=1 until clr_ovf, after which ovf=0.
- Saturate down (SATURATE=1): load 1, up_dn=0, 3 events -> count 0,0,0. tc pulses on the 2nd and 3rd events, and ovf=1.
- Load priority/clamp (MAX_COUNT=9): load_val=15 with load coinciding with an evt -> count=9, no increment, tc=0.
- Enable gating: en=0 for 3 events -> count unchanged and evt pulses 3 times. Raise en while i is held high -> no count change. The next rising edge of i increments by 1.
- Simultaneous ovf set/clear: at count=MAX_COUNT, event plus clr_ovf on the same edge -> ovf=1. clr_ovf alone on a later edge -> ovf=0. Mid-sequence rst -> count=0, ovf=0 next cycle.
